// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM stream reader: FSM state encoding and a
// ceil(log2) helper for sizing pointers and counters.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ram_stream_reader_fifo.sv
// fifo_sync: synchronous FIFO used as the reader's output buffer.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   wr_en_i/wr_data_i  push (caller guarantees no push when full)
//   rd_en_i         pop (caller guarantees no pop when empty)
//   rd_data_o       head word, forced to 0 while empty
//   empty_o         FIFO empty
//   count_o         occupancy, 0..Depth
module fifo_sync
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned Width = 11,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_en_i,
  input  logic [Width-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [Width-1:0]       rd_data_o,
  output logic                   empty_o,
  output logic [clog2(Depth):0]  count_o
);

  localparam int unsigned PtrW = clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + {{PtrW{1'b0}}, wr_en_i} - {{PtrW{1'b0}}, rd_en_i};
    end
  end

  // Storage needs no reset: nothing is visible until a word is written.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  // Zeroing the head while empty keeps downstream data at 0 out of reset.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads cfg_count consecutive words from a RAM starting at
// cfg_base_addr (wrapping) and streams them out over a valid/ready interface.
// Ports:
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   cfg_start_i/base_addr_i/count_i transfer request, sampled in idle only
//   busy_o, done_o                  status; done_o pulses once per transfer
//   s_read_req_o/addr_o/data_i      RAM read port, data RAM_LATENCY (0 or 1) later
//   m_valid_o/ready_i/data_o/last_o output stream, driven from the FIFO head
// FIFO_DEPTH must be a power of two, at least 4.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 10,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned RAM_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_start_i,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr_i,
  input  logic [ADDR_WIDTH:0]   cfg_count_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  s_read_req_o,
  output logic [ADDR_WIDTH-1:0] s_read_addr_o,
  input  logic [DATA_WIDTH-1:0] s_read_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o
);

  localparam int unsigned CntW = clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OccW = CntW + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  rd_vld_q, rd_last_q;

  logic                  req_last;
  logic                  in_flight;
  logic                  pop;
  logic                  fifo_wr;
  logic                  fifo_wr_last;
  logic                  fifo_empty;
  logic [CntW-1:0]       fifo_cnt;
  logic [DATA_WIDTH:0]   fifo_head;
  logic [OccW-1:0]       occ;

  assign req_last  = (rem_q == (ADDR_WIDTH+1)'(1));
  assign in_flight = (RAM_LATENCY == 1) ? rd_vld_q : 1'b0;
  assign pop       = m_valid_o && m_ready_i;

  // Credit check: words that will still occupy a FIFO slot after this edge.
  assign occ = {{(OccW-1){1'b0}}, in_flight} + {1'b0, fifo_cnt} - {{(OccW-1){1'b0}}, pop};

  assign s_read_req_o  = (state_q == StRun) && (rem_q != '0) && (occ < OccW'(FIFO_DEPTH));
  assign s_read_addr_o = addr_q;

  // With zero latency the RAM answers in the request cycle, so write directly.
  assign fifo_wr      = (RAM_LATENCY == 1) ? rd_vld_q  : s_read_req_o;
  assign fifo_wr_last = (RAM_LATENCY == 1) ? rd_last_q : (s_read_req_o && req_last);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    case (state_q)
      StIdle: begin
        if (cfg_start_i) begin
          addr_d  = cfg_base_addr_i;
          rem_d   = cfg_count_i;
          state_d = (cfg_count_i == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (s_read_req_o) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          rem_d  = rem_q - (ADDR_WIDTH+1)'(1);
        end
        if (pop && m_last_o) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      rem_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      rd_vld_q  <= s_read_req_o;
      rd_last_q <= s_read_req_o && req_last;
    end
  end

  fifo_sync #(
    .Width (DATA_WIDTH + 1),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (fifo_wr),
    .wr_data_i ({fifo_wr_last, s_read_data_i}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .empty_o   (fifo_empty),
    .count_o   (fifo_cnt)
  );

  assign m_valid_o = !fifo_empty;
  assign m_last_o  = fifo_head[DATA_WIDTH];
  assign m_data_o  = fifo_head[DATA_WIDTH-1:0];

  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StDone);

endmodule
